// File: rtl/buzzer_sequencer.sv
// Buzzer sequencer: arbitrates key click, hourly chime and alarm onto one tone
// generator and plays each source's on/off beep pattern in prescaled ticks.
module buzzer_sequencer #(
    parameter int unsigned TICK_DIV  = 240000,
    parameter int unsigned KEY_ON    = 5,
    parameter int unsigned CHIME_ON  = 20,
    parameter int unsigned CHIME_OFF = 30,
    parameter int unsigned ALARM_ON  = 10,
    parameter int unsigned ALARM_OFF = 10,
    parameter int unsigned ALARM_GAP = 50,
    parameter int unsigned ALARM_MAX = 60
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_key_req,
    input  logic       i_chime_req,
    input  logic [3:0] i_chime_n,
    input  logic       i_alarm_req,
    input  logic       i_alarm_stop,
    output logic       o_beep_en,
    output logic [1:0] o_tone_sel,
    output logic [2:0] o_grant,
    output logic       o_busy
);
    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Source codes double as the tone index and the GRANT bit position.
    localparam logic [1:0] SrcKey   = 2'd0;
    localparam logic [1:0] SrcChime = 2'd1;
    localparam logic [1:0] SrcAlarm = 2'd2;

    typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

    state_e          r_state, w_state_nxt;
    logic [1:0]      r_src, w_src_nxt;
    logic [3:0]      r_beeps, w_beeps_nxt;
    logic [7:0]      r_bursts, w_bursts_nxt;
    logic [7:0]      r_tick;
    logic [PreW-1:0] r_pre;
    logic            r_key_pend, r_chime_pend, r_alarm_pend;
    logic [3:0]      r_chime_n;
    logic            r_beep_en;
    logic [1:0]      r_tone_sel;
    logic [2:0]      r_grant;

    logic       w_tick_end, w_expire;
    logic       w_alarm_new, w_alarm_ok, w_alarm_run;
    logic       w_grant_key, w_grant_chime, w_grant_alarm;
    logic [7:0] w_dur;

    // STOP in the same cycle cancels both a new and an already pending alarm.
    assign w_alarm_new = i_alarm_req && !i_alarm_stop;
    assign w_alarm_ok  = r_alarm_pend && !i_alarm_stop;
    assign w_alarm_run = (r_state != StIdle) && (r_src == SrcAlarm);
    assign w_tick_end  = (r_pre == PreW'(TICK_DIV - 1));
    assign w_expire    = w_tick_end && (r_tick == w_dur - 8'd1);

    // Duration in ticks of the current state for the active source.
    always_comb begin
        w_dur = 8'd0;
        unique case (r_state)
            StOn: begin
                case (r_src)
                    SrcKey:   w_dur = 8'(KEY_ON);
                    SrcChime: w_dur = 8'(CHIME_ON);
                    default:  w_dur = 8'(ALARM_ON);
                endcase
            end
            StOff:   w_dur = (r_src == SrcChime) ? 8'(CHIME_OFF) : 8'(ALARM_OFF);
            StGap:   w_dur = 8'(ALARM_GAP);
            default: w_dur = 8'd0;
        endcase
    end

    // Next-state: grant from IDLE by priority, alarm stop/preempt, pattern stepping.
    always_comb begin
        w_state_nxt   = r_state;
        w_src_nxt     = r_src;
        w_beeps_nxt   = r_beeps;
        w_bursts_nxt  = r_bursts;
        w_grant_key   = 1'b0;
        w_grant_chime = 1'b0;
        w_grant_alarm = 1'b0;
        if (r_state == StIdle) begin
            if (w_alarm_ok) begin
                w_state_nxt   = StOn;
                w_src_nxt     = SrcAlarm;
                w_beeps_nxt   = 4'd4;
                w_bursts_nxt  = 8'd0;
                w_grant_alarm = 1'b1;
            end else if (r_chime_pend) begin
                w_state_nxt   = StOn;
                w_src_nxt     = SrcChime;
                w_beeps_nxt   = r_chime_n;
                w_grant_chime = 1'b1;
            end else if (r_key_pend) begin
                w_state_nxt   = StOn;
                w_src_nxt     = SrcKey;
                w_beeps_nxt   = 4'd1;
                w_grant_key   = 1'b1;
            end
        end else if (w_alarm_run && i_alarm_stop) begin
            w_state_nxt = StIdle;
        end else if (!w_alarm_run && (w_alarm_new || w_alarm_ok)) begin
            // Key/chime are abandoned, not resumed; the alarm is granted from IDLE.
            w_state_nxt = StIdle;
        end else if (w_expire) begin
            unique case (r_state)
                StOn: begin
                    w_beeps_nxt = r_beeps - 4'd1;
                    if (w_beeps_nxt != 4'd0) begin
                        w_state_nxt = StOff;
                    end else if (r_src != SrcAlarm) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_bursts_nxt = r_bursts + 8'd1;
                        w_state_nxt  = (w_bursts_nxt == 8'(ALARM_MAX)) ? StIdle : StGap;
                    end
                end
                StOff: w_state_nxt = StOn;
                StGap: begin
                    w_state_nxt = StOn;
                    w_beeps_nxt = 4'd4;
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    // State, pattern counters and the prescaler, which restarts on every state entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_src    <= SrcKey;
            r_beeps  <= 4'd0;
            r_bursts <= 8'd0;
            r_tick   <= 8'd0;
            r_pre    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_src    <= w_src_nxt;
            r_beeps  <= w_beeps_nxt;
            r_bursts <= w_bursts_nxt;
            if (w_state_nxt != r_state) begin
                r_pre  <= '0;
                r_tick <= 8'd0;
            end else if (r_state != StIdle) begin
                if (w_tick_end) begin
                    r_pre  <= '0;
                    r_tick <= r_tick + 8'd1;
                end else begin
                    r_pre  <= r_pre + 1'b1;
                end
            end
        end
    end

    // Pending request flags; a new request wins over the grant that clears it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_key_pend   <= 1'b0;
            r_chime_pend <= 1'b0;
            r_alarm_pend <= 1'b0;
            r_chime_n    <= 4'd0;
        end else begin
            if (i_key_req) begin
                r_key_pend <= 1'b1;
            end else if (w_grant_key) begin
                r_key_pend <= 1'b0;
            end
            if (i_chime_req && (i_chime_n != 4'd0)) begin
                r_chime_pend <= 1'b1;
                r_chime_n    <= i_chime_n;
            end else if (w_grant_chime) begin
                r_chime_pend <= 1'b0;
            end
            if (i_alarm_stop) begin
                r_alarm_pend <= 1'b0;
            end else if (i_alarm_req) begin
                r_alarm_pend <= 1'b1;
            end else if (w_grant_alarm) begin
                r_alarm_pend <= 1'b0;
            end
        end
    end

    // Registered tone-generator outputs derived from the next state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_beep_en  <= 1'b0;
            r_tone_sel <= 2'd0;
            r_grant    <= 3'd0;
        end else begin
            r_beep_en  <= (w_state_nxt == StOn);
            r_tone_sel <= (w_state_nxt == StIdle) ? 2'd0 : w_src_nxt;
            r_grant    <= (w_state_nxt == StIdle) ? 3'd0 : (3'b001 << w_src_nxt);
        end
    end

    assign o_beep_en  = r_beep_en;
    assign o_tone_sel = r_tone_sel;
    assign o_grant    = r_grant;
    assign o_busy     = (r_state != StIdle);

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Scoreboard bench for buzzer_sequencer: stimulus queues the expected output
// changes with their cycle; the monitor compares every observed output change.
module tb_buzzer_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_req = 1'b0;
    logic       chime_req = 1'b0;
    logic [3:0] chime_n = 4'd0;
    logic       alarm_req = 1'b0;
    logic       alarm_stop = 1'b0;
    logic       beep_en;
    logic [1:0] tone_sel;
    logic [2:0] grant;
    logic       busy;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int t0;
    int s;

    // Packed outputs: {beep_en, grant[2:0], tone_sel[1:0], busy}
    typedef struct {
        int         c;
        logic [6:0] o;
        string      name;
    } exp_t;
    exp_t exp_q[$];

    logic [6:0] mon_cur;
    logic [6:0] mon_last = 7'd0;
    exp_t       mon_e;

    buzzer_sequencer #(
        .TICK_DIV (4),
        .KEY_ON   (5),
        .CHIME_ON (20),
        .CHIME_OFF(30),
        .ALARM_ON (10),
        .ALARM_OFF(10),
        .ALARM_GAP(50),
        .ALARM_MAX(2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_key_req   (key_req),
        .i_chime_req (chime_req),
        .i_chime_n   (chime_n),
        .i_alarm_req (alarm_req),
        .i_alarm_stop(alarm_stop),
        .o_beep_en   (beep_en),
        .o_tone_sel  (tone_sel),
        .o_grant     (grant),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic b, input logic [2:0] g, input logic [1:0] t,
                        input logic bz, input string nm);
        exp_t e;
        e.c    = c;
        e.o    = {b, g, t, bz};
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic exp_on(input int c, input logic [1:0] src, input string nm);
        logic [2:0] g;
        g = 3'b001 << src;
        push(c, 1'b1, g, src, 1'b1, nm);
    endtask

    task automatic exp_off(input int c, input logic [1:0] src, input string nm);
        logic [2:0] g;
        g = 3'b001 << src;
        push(c, 1'b0, g, src, 1'b1, nm);
    endtask

    task automatic exp_idle(input int c, input string nm);
        push(c, 1'b0, 3'd0, 2'd0, 1'b0, nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Monitor: every change of the output bundle must match the next queued event.
    always @(negedge clk) begin
        mon_cur = {beep_en, grant, tone_sel, busy};
        if (mon_cur !== mon_last) begin
            mon_last = mon_cur;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: cycle %0d outputs %b, expected no change",
                         cyc, mon_cur);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.c != cyc || mon_e.o !== mon_cur) begin
                    bad++;
                    $display("FAIL %s: cycle %0d outputs %b, expected cycle %0d outputs %b",
                             mon_e.name, cyc, mon_cur, mon_e.c, mon_e.o);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset_beep_en", int'(beep_en), 0);
        check("reset_grant", int'(grant), 0);
        check("reset_tone_sel", int'(tone_sel), 0);
        check("reset_busy", int'(busy), 0);

        // Key click: 5 ticks x 4 clocks = 20 cycles of tone.
        t0 = cyc;
        exp_on(t0 + 2, 2'd0, "key_on");
        exp_idle(t0 + 22, "key_end");
        key_req = 1'b1; step(); key_req = 1'b0;
        wait_to(t0 + 40);
        check("key_busy_after", int'(busy), 0);

        // Chime N=3: 80-cycle beeps separated by 120-cycle gaps.
        t0 = cyc;
        exp_on(t0 + 2, 2'd1, "chime_on1");
        exp_off(t0 + 82, 2'd1, "chime_off1");
        exp_on(t0 + 202, 2'd1, "chime_on2");
        exp_off(t0 + 282, 2'd1, "chime_off2");
        exp_on(t0 + 402, 2'd1, "chime_on3");
        exp_idle(t0 + 482, "chime_end");
        chime_n = 4'd3; chime_req = 1'b1; step(); chime_req = 1'b0;
        wait_to(t0 + 500);

        // Chime N=0 is ignored.
        t0 = cyc;
        chime_n = 4'd0; chime_req = 1'b1; step(); chime_req = 1'b0;
        wait_to(t0 + 4);
        check("chime_n0_busy", int'(busy), 0);
        wait_to(t0 + 20);

        // Alarm preempts a running chime; STOP returns to IDLE with no chime resume.
        t0 = cyc;
        exp_on(t0 + 2, 2'd1, "preempt_chime_on");
        exp_idle(t0 + 41, "preempt_abort");
        exp_on(t0 + 42, 2'd2, "preempt_alarm_on");
        exp_idle(t0 + 61, "alarm_stop_idle");
        chime_n = 4'd12; chime_req = 1'b1; step(); chime_req = 1'b0;
        wait_to(t0 + 40);
        alarm_req = 1'b1; step(); alarm_req = 1'b0;
        wait_to(t0 + 45);
        check("preempt_grant", int'(grant), 4);
        wait_to(t0 + 60);
        alarm_stop = 1'b1; step(); alarm_stop = 1'b0;
        wait_to(t0 + 260);
        check("no_chime_resume", int'(busy), 0);

        // Full alarm with ALARM_MAX=2: two 4-beep bursts, one 200-cycle gap, then IDLE.
        t0 = cyc;
        s  = t0 + 2;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) begin
                exp_on(s + b * 480 + i * 80, 2'd2, "alarm_beep_on");
                if (i < 3) exp_off(s + b * 480 + i * 80 + 40, 2'd2, "alarm_beep_off");
            end
            if (b == 0) exp_off(s + 280, 2'd2, "alarm_gap");
            else exp_idle(s + 760, "alarm_self_end");
        end
        alarm_req = 1'b1; step(); alarm_req = 1'b0;
        wait_to(s + 800);
        check("alarm_done_busy", int'(busy), 0);

        // Key and chime together: chime first, key one cycle later; extra key merges.
        t0 = cyc;
        exp_on(t0 + 2, 2'd1, "both_chime_on");
        exp_idle(t0 + 82, "both_chime_end");
        exp_on(t0 + 83, 2'd0, "both_key_on");
        exp_idle(t0 + 103, "both_key_end");
        chime_n = 4'd1; chime_req = 1'b1; key_req = 1'b1; step();
        chime_req = 1'b0; key_req = 1'b0;
        wait_to(t0 + 10);
        key_req = 1'b1; step(); key_req = 1'b0;
        wait_to(t0 + 20);
        key_req = 1'b1; step(); key_req = 1'b0;
        wait_to(t0 + 140);

        // Reset during alarm ON drops BEEP_EN at once and discards the pending key.
        t0 = cyc;
        exp_on(t0 + 2, 2'd2, "rst_alarm_on");
        exp_idle(t0 + 10, "rst_async_idle");
        alarm_req = 1'b1; step(); alarm_req = 1'b0;
        wait_to(t0 + 5);
        key_req = 1'b1; step(); key_req = 1'b0;
        wait_to(t0 + 10);
        rst = 1'b1;
        #1;
        check("rst_beep_async", int'(beep_en), 0);
        repeat (3) step();
        rst = 1'b0;
        wait_to(t0 + 60);
        check("rst_no_activity", int'(busy), 0);

        // ALARM_REQ and ALARM_STOP together: STOP wins, no beep.
        t0 = cyc;
        alarm_req = 1'b1; alarm_stop = 1'b1; step();
        alarm_req = 1'b0; alarm_stop = 1'b0;
        wait_to(t0 + 30);
        check("req_stop_busy", int'(busy), 0);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events: %0d expected output changes never seen, expected 0",
                     exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
